// File: rtl/key_conditioner_if.sv
// Bundle of the key_conditioner's push-button, game-core and conditioned-output signals.
interface key_conditioner_if;
    logic [3:0] KEY;
    logic       game_over;
    logic [3:0] key_level;
    logic [3:0] key_press;
    logic [3:0] key_release;
    logic       move_right;
    logic       move_left;
    logic [4:0] boost;
    logic       start;

    // Board / game-core side: drives the raw keys and game_over, reads the results.
    modport master (
        output KEY,
        output game_over,
        input  key_level,
        input  key_press,
        input  key_release,
        input  move_right,
        input  move_left,
        input  boost,
        input  start
    );

    // Conditioner side.
    modport slave (
        input  KEY,
        input  game_over,
        output key_level,
        output key_press,
        output key_release,
        output move_right,
        output move_left,
        output boost,
        output start
    );
endinterface

// File: rtl/key_conditioner.sv
// Push-button conditioner: synchronise and debounce four active-low keys,
// generate press/release pulses, paddle direction with a hold-time boost,
// and a start/pause run flag.
module key_conditioner #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int BOOST_PERIOD    = 8388608,
    parameter int BOOST_MAX       = 31
) (
    input  logic                CLOCK_50,
    input  logic                RESET_N,
    key_conditioner_if.slave    bus
);
    localparam int DW = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
    localparam int TW = (BOOST_PERIOD < 2) ? 1 : $clog2(BOOST_PERIOD + 1);
    localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(BOOST_PERIOD - 1);
    localparam logic [4:0]    BMAX      = 5'(BOOST_MAX);

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    // Synchroniser holds the pressed-sense value, so 0 means released.
    logic [3:0] sync1_q, sync2_q;
    logic [3:0] key_level_q, key_level_d;
    logic [3:0] key_press_q, key_release_q;
    logic [TW-1:0] tick_q, tick_d;
    logic [4:0] boost_q, boost_d;
    logic       hold;
    state_t     state_q;
    logic       start_q;

    // Two-flop synchroniser on the inverted raw keys.
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= ~bus.KEY;
            sync2_q <= sync1_q;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_key
            logic [DW-1:0] cnt_q, cnt_d;
            logic          level_d;

            // Count consecutive cycles of disagreement; toggle the level once it has persisted.
            always_comb begin
                cnt_d   = '0;
                level_d = key_level_q[gi];
                if (sync2_q[gi] != key_level_q[gi]) begin
                    if (cnt_q == DEB_LAST) begin
                        level_d = ~key_level_q[gi];
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end

            // Per-key debounce counter state.
            always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
                if (!RESET_N) begin
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_d;
                end
            end

            assign key_level_d[gi] = level_d;
        end
    endgenerate

    // Debounced level plus registered edge pulses that line up with the level change.
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            key_level_q   <= '0;
            key_press_q   <= '0;
            key_release_q <= '0;
        end else begin
            key_level_q   <= key_level_d;
            key_press_q   <= key_level_d & ~key_level_q;
            key_release_q <= ~key_level_d & key_level_q;
        end
    end

    assign hold = key_level_q[0] ^ key_level_q[1];

    // Boost grows by one every BOOST_PERIOD held cycles and snaps back to 1 when the hold ends.
    always_comb begin
        tick_d  = '0;
        boost_d = 5'd1;
        if (hold) begin
            boost_d = boost_q;
            if (tick_q == TICK_LAST) begin
                tick_d = '0;
                if (boost_q < BMAX) begin
                    boost_d = boost_q + 5'd1;
                end
            end else begin
                tick_d = tick_q + 1'b1;
            end
        end
    end

    // Boost and tick counter state.
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            tick_q  <= '0;
            boost_q <= 5'd1;
        end else begin
            tick_q  <= tick_d;
            boost_q <= boost_d;
        end
    end

    // Run/pause FSM; game_over wins over any key press in the same cycle.
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= IDLE;
            start_q <= 1'b0;
        end else if (bus.game_over) begin
            state_q <= IDLE;
            start_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (key_press_q[3]) begin
                        state_q <= RUN;
                        start_q <= 1'b1;
                    end
                end
                RUN: begin
                    if (key_press_q[2]) begin
                        state_q <= IDLE;
                        start_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    start_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.key_level   = key_level_q;
    assign bus.key_press   = key_press_q;
    assign bus.key_release = key_release_q;
    assign bus.move_right  = key_level_q[0] & ~key_level_q[1];
    assign bus.move_left   = key_level_q[1] & ~key_level_q[0];
    assign bus.boost       = boost_q;
    assign bus.start       = start_q;
endmodule

// File: tb/tb_key_conditioner.sv
// Scoreboard bench for key_conditioner (DEBOUNCE_CYCLES=4, BOOST_PERIOD=8, BOOST_MAX=5).
// Stimulus pushes expected output-change events with their cycle numbers;
// a negedge monitor pops one entry for every observed change and compares.
module tb_key_conditioner;
    localparam int EV_LEVEL = 0, EV_PRESS = 1, EV_RELEASE = 2, EV_MOVE = 3, EV_BOOST = 4, EV_START = 5;

    typedef struct {
        int         kind;
        logic [7:0] val;
        int         cyc;
    } exp_t;

    logic clk;
    logic rst_n;
    int   cyc;
    int   checks;
    int   errors;
    exp_t q[$];
    string kname[6] = '{"level", "press", "release", "move", "boost", "start"};

    logic [3:0] prev_level, prev_press, prev_release;
    logic [1:0] prev_move;
    logic [4:0] prev_boost;
    logic       prev_start;

    key_conditioner_if bus ();

    key_conditioner #(
        .DEBOUNCE_CYCLES(4),
        .BOOST_PERIOD   (8),
        .BOOST_MAX      (5)
    ) dut (
        .CLOCK_50(clk),
        .RESET_N (rst_n),
        .bus     (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic push(input int c, input int kind, input int v);
        exp_t e;
        e.kind = kind;
        e.val  = 8'(v);
        e.cyc  = c;
        q.push_back(e);
    endtask

    task automatic observe(input int kind, input logic [7:0] v);
        exp_t e;
        checks++;
        if (q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_%s: got val=%0h at cyc=%0d, required no change", kname[kind], v, cyc);
        end else begin
            e = q.pop_front();
            if (e.kind != kind || e.val !== v || e.cyc != cyc) begin
                errors++;
                $display("FAIL event_%s: got %s=%0h at cyc=%0d, required %s=%0h at cyc=%0d",
                         kname[e.kind], kname[kind], v, cyc, kname[e.kind], e.val, e.cyc);
            end else begin
                $display("ok   %s=%0h at cyc=%0d", kname[kind], v, cyc);
            end
        end
    endtask

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end else begin
            $display("ok   %s=%0d", name, act);
        end
    endtask

    // Monitor: every change on any output is one transaction checked against the queue.
    initial begin
        prev_level = '0; prev_press = '0; prev_release = '0;
        prev_move = '0; prev_boost = 5'd1; prev_start = 1'b0;
    end

    always @(negedge clk) begin
        if (bus.key_level !== prev_level) observe(EV_LEVEL, 8'(bus.key_level));
        if (bus.key_press !== prev_press) observe(EV_PRESS, 8'(bus.key_press));
        if (bus.key_release !== prev_release) observe(EV_RELEASE, 8'(bus.key_release));
        if ({bus.move_left, bus.move_right} !== prev_move) observe(EV_MOVE, 8'({bus.move_left, bus.move_right}));
        if (bus.boost !== prev_boost) observe(EV_BOOST, 8'(bus.boost));
        if (bus.start !== prev_start) observe(EV_START, 8'(bus.start));
        prev_level   = bus.key_level;
        prev_press   = bus.key_press;
        prev_release = bus.key_release;
        prev_move    = {bus.move_left, bus.move_right};
        prev_boost   = bus.boost;
        prev_start   = bus.start;
    end

    task automatic wait_until(input int c);
        @(negedge clk);
        while (cyc < c) @(negedge clk);
    endtask

    // Press key k long enough to register, optionally with a one-cycle game_over
    // coincident with its press pulse; st = expected new start value, or -1 for none.
    task automatic tap(input int k, input bit go, input int st);
        int n;
        n = cyc;
        bus.KEY[k] = 1'b0;
        push(n + 6, EV_LEVEL, 1 << k);
        push(n + 6, EV_PRESS, 1 << k);
        if (k < 2) push(n + 6, EV_MOVE, (k == 0) ? 1 : 2);
        push(n + 7, EV_PRESS, 0);
        if (st >= 0) push(n + 7, EV_START, st);
        push(n + 13, EV_LEVEL, 0);
        push(n + 13, EV_RELEASE, 1 << k);
        if (k < 2) push(n + 13, EV_MOVE, 0);
        push(n + 14, EV_RELEASE, 0);
        wait_until(n + 6);
        if (go) bus.game_over = 1'b1;
        wait_until(n + 7);
        bus.game_over = 1'b0;
        bus.KEY[k] = 1'b1;
        wait_until(n + 20);
    endtask

    initial begin
        int n;
        checks = 0;
        errors = 0;
        bus.KEY = 4'hF;
        bus.game_over = 1'b0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_key_level", int'(bus.key_level), 0);
        chk("reset_key_press", int'(bus.key_press), 0);
        chk("reset_key_release", int'(bus.key_release), 0);
        chk("reset_move", int'({bus.move_left, bus.move_right}), 0);
        chk("reset_boost", int'(bus.boost), 1);
        chk("reset_start", int'(bus.start), 0);
        rst_n = 1'b1;
        wait_until(cyc + 3);

        // 3-cycle glitch on KEY[0]: no output may move.
        n = cyc;
        bus.KEY[0] = 1'b0;
        wait_until(n + 3);
        bus.KEY[0] = 1'b1;
        wait_until(n + 15);

        // Full press/release of KEY[0] (right), KEY[1] (left).
        tap(0, 1'b0, -1);
        tap(1, 1'b0, -1);

        // Hold KEY[1]: boost 2..5 every 8 cycles, saturate, then add KEY[0].
        n = cyc;
        bus.KEY[1] = 1'b0;
        push(n + 6, EV_LEVEL, 2);
        push(n + 6, EV_PRESS, 2);
        push(n + 6, EV_MOVE, 2);
        push(n + 7, EV_PRESS, 0);
        push(n + 14, EV_BOOST, 2);
        push(n + 22, EV_BOOST, 3);
        push(n + 30, EV_BOOST, 4);
        push(n + 38, EV_BOOST, 5);
        push(n + 62, EV_LEVEL, 3);
        push(n + 62, EV_PRESS, 1);
        push(n + 62, EV_MOVE, 0);
        push(n + 63, EV_PRESS, 0);
        push(n + 63, EV_BOOST, 1);
        push(n + 76, EV_LEVEL, 0);
        push(n + 76, EV_RELEASE, 3);
        push(n + 77, EV_RELEASE, 0);
        wait_until(n + 56);
        bus.KEY[0] = 1'b0;
        wait_until(n + 70);
        bus.KEY[1:0] = 2'b11;
        wait_until(n + 85);

        // Start/pause: KEY[2] in IDLE is a no-op, KEY[3] starts, KEY[2] pauses.
        tap(2, 1'b0, -1);
        tap(3, 1'b0, 1);
        tap(3, 1'b0, -1);
        tap(2, 1'b0, 0);

        // game_over coincident with key_press[3]: from RUN and from IDLE.
        tap(3, 1'b0, 1);
        tap(3, 1'b1, 0);
        tap(3, 1'b1, -1);

        // Reset mid-hold with boost=3 while running.
        tap(3, 1'b0, 1);
        n = cyc;
        bus.KEY[1] = 1'b0;
        push(n + 6, EV_LEVEL, 2);
        push(n + 6, EV_PRESS, 2);
        push(n + 6, EV_MOVE, 2);
        push(n + 7, EV_PRESS, 0);
        push(n + 14, EV_BOOST, 2);
        push(n + 22, EV_BOOST, 3);
        push(n + 26, EV_LEVEL, 0);
        push(n + 26, EV_MOVE, 0);
        push(n + 26, EV_BOOST, 1);
        push(n + 26, EV_START, 0);
        push(n + 33, EV_LEVEL, 2);
        push(n + 33, EV_PRESS, 2);
        push(n + 33, EV_MOVE, 2);
        push(n + 34, EV_PRESS, 0);
        push(n + 40, EV_LEVEL, 0);
        push(n + 40, EV_RELEASE, 2);
        push(n + 40, EV_MOVE, 0);
        push(n + 41, EV_RELEASE, 0);
        wait_until(n + 25);
        chk("boost_before_reset", int'(bus.boost), 3);
        rst_n = 1'b0;
        #1;
        chk("midreset_boost", int'(bus.boost), 1);
        chk("midreset_start", int'(bus.start), 0);
        chk("midreset_key_level", int'(bus.key_level), 0);
        wait_until(n + 27);
        rst_n = 1'b1;
        wait_until(n + 34);
        bus.KEY[1] = 1'b1;
        wait_until(n + 50);

        while (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            checks++;
            errors++;
            $display("FAIL missing_%s: got no change, required val=%0h at cyc=%0d", kname[e.kind], e.val, e.cyc);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/key_conditioner.md
KEY_CONDITIONER -- requirements
Module: key_conditioner

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 1000000, meaning consecutive stable cycles required to accept a key change (20 ms at 50 MHz).
REQ-002 SHALL have parameter BOOST_PERIOD, default 8388608, meaning cycles per boost increment while a paddle key is held.
REQ-003 SHALL have parameter BOOST_MAX, default 31, meaning saturation value of boost.
REQ-004 SHALL have ports, clock and reset first, each as name, direction, width, meaning:
- CLOCK_50  input  1  system clock, all logic on rising edge.
- RESET_N  input  1  asynchronous, active-low reset.
- KEY  input  4  raw push-buttons, active-low, asynchronous to CLOCK_50.
- game_over  input  1  level from the game core; ball left the field.
- key_level  output  4  debounced state, active-high (1 = pressed).
- key_press  output  4  one-cycle pulse per debounced press.
- key_release  output  4  one-cycle pulse per debounced release.
- move_right  output  1  key_level[0] & ~key_level[1].
- move_left  output  1  key_level[1] & ~key_level[0].
- boost  output  5  paddle step size, 1..BOOST_MAX.
- start  output  1  game running flag.

Function
REQ-005 SHALL pass each KEY bit through a 2-flop synchronizer, then invert it so the synchronized value is 1 when pressed.
REQ-006 SHALL keep one debounce counter per key, at least ceil(log2(DEBOUNCE_CYCLES+1)) bits wide.
- Counter clears whenever the synchronized value equals key_level.
- Otherwise it increments.
- When it reaches DEBOUNCE_CYCLES-1, key_level toggles on the next edge and the counter clears.
REQ-007 SHALL assert key_press[i] (or key_release[i]) for exactly the one cycle in which key_level[i] has just risen (or fallen), registered, and never both in the same cycle.
REQ-008 SHALL make a glitch shorter than DEBOUNCE_CYCLES cycles produce no change on key_level, key_press or key_release.
REQ-009 SHALL derive move_right and move_left combinationally from key_level; both are 0 when both keys or neither key is held.
REQ-010 SHALL drive boost as follows:
- Hold condition = move_right | move_left.
- While the hold condition is false: boost = 1 and the tick counter = 0.
- On the first cycle the hold condition is true, the tick counter starts from 0.
- Every BOOST_PERIOD cycles of continuous hold, boost increments by 1, saturating at BOOST_MAX.
- The tick counter keeps running while boost is saturated.
REQ-011 SHALL return boost to 1 on the cycle after the hold condition goes false, including a change from one key to both keys.
REQ-012 SHALL implement the start FSM with states IDLE (start=0) and RUN (start=1); start is registered and decoded from the state.
REQ-013 SHALL apply these FSM transitions:
- IDLE -> RUN on key_press[3] while game_over=0.
- RUN -> IDLE on key_press[2] (pause).
- Any state -> IDLE whenever game_over=1.
REQ-014 SHALL give game_over priority over key_press[3] and key_press[2] in the same cycle; a key_press[3] that arrives while game_over=1 is discarded, not remembered.
REQ-015 SHALL treat key_press[3] in RUN and key_press[2] in IDLE as no-ops.
REQ-016 SHALL sample game_over directly, without synchronization (same clock domain).

Reset
REQ-017 SHALL, while RESET_N=0, asynchronously force:
- synchronizer flops to 0 (released);
- key_level = 0, key_press = 0, key_release = 0;
- all counters to 0;
- boost = 1;
- FSM = IDLE (start = 0).
REQ-018 SHALL, on reset assertion mid-debounce or mid-hold, discard the partial count; after release, keys held through reset need a full DEBOUNCE_CYCLES to register a press.
REQ-019 SHALL deassert RESET_N synchronously to CLOCK_50 externally; the block itself adds no reset synchronizer.

Verification (DEBOUNCE_CYCLES=4, BOOST_PERIOD=8, BOOST_MAX=5)
REQ-020 SHALL cover: KEY[0] low for 3 cycles, then high -> key_level[0] stays 0 and key_press[0] never pulses.
REQ-021 SHALL cover: KEY[0] held low -> key_level[0]=1 exactly 2+4 cycles after the KEY edge, key_press[0] high for 1 cycle, move_right=1; on release, key_release[0] pulses once.
REQ-022 SHALL cover: KEY[1] held for 50 cycles after debounce -> boost reads 1,2,3,4,5 at 8-cycle intervals, then stays 5; pressing KEY[0] as well -> boost=1 on the next cycle and move_left=0.
REQ-023 SHALL cover: with game_over=0, press KEY[3] -> start=1 one cycle after key_press[3]; then press KEY[2] -> start=0.
REQ-024 SHALL cover: start=1, pulse game_over for 1 cycle coincident with key_press[3] -> start=0 and it remains 0 after game_over falls.
REQ-025 SHALL cover: RESET_N pulsed low while KEY[1] is held and boost=3 -> boost=1, start=0 and key_level=0 immediately; key_level[1]=1 returns 6 cycles after reset release.
